// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer: default geometry,
// pipeline fill length and the FSM state encoding.
package systolic_pkg;

    localparam int N_DEF      = 4;
    localparam int PE_LAT_DEF = 1;
    localparam int VEC_W_DEF  = 8;
    localparam int FILL_DEF   = N_DEF * PE_LAT_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_SWAP,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Cycles for an activation to cross all N rows and reach the bottom edge.
    function automatic int fill_len(input int n, input int pe_lat);
        return n * pe_lat;
    endfunction

endpackage

// File: rtl/systolic_seq_valid_delay.sv
// Fixed-depth shift register that turns the row-0 activation strobe/index
// into the column-0 result strobe/index; synchronous clear flushes it.
module valid_delay #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/systolic_seq.sv
// Control sequencer for one weight-stationary N x N tile: weight load,
// dormant->active swap, activation streaming and result-stream flagging.
//
// state    | meaning
// S_IDLE   | waiting for start; all outputs 0
// S_LOAD_W | shifting weight rows 0..N-1 into the dormant registers
// S_SWAP   | one-cycle broadcast of the dormant->active swap
// S_STREAM | issuing activation vectors 0..num_vec-1
// S_DRAIN  | letting the last vector fill and de-skew out of the array
// S_DONE   | one-cycle completion pulse
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int PE_LAT = PE_LAT_DEF,
    parameter int VEC_W  = VEC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VEC_W-1:0]     num_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 w_en,
    output logic [$clog2(N)-1:0] w_addr,
    output logic                 switch,
    output logic                 act_valid,
    output logic [VEC_W-1:0]     act_addr,
    output logic                 res_valid,
    output logic [VEC_W-1:0]     res_addr
);

    localparam int FILL = fill_len(N, PE_LAT);
    localparam int AW   = $clog2(N);
    localparam logic [VEC_W-1:0] LOAD_LAST  = VEC_W'(N - 1);
    localparam logic [VEC_W-1:0] DRAIN_LAST = VEC_W'(FILL + N - 2);

    state_t           state, state_nx;
    logic [VEC_W-1:0] cnt, cnt_nx;
    logic [VEC_W-1:0] nv_q, nv_nx;
    logic [VEC_W:0]   res_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            nv_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            nv_q  <= nv_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        nv_nx     = nv_q;
        done      = 1'b0;
        w_en      = 1'b0;
        w_addr    = '0;
        switch    = 1'b0;
        act_valid = 1'b0;
        act_addr  = '0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    nv_nx    = num_vec;
                    state_nx = (num_vec == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                w_en   = 1'b1;
                w_addr = cnt[AW-1:0];
                if (cnt == LOAD_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_SWAP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_SWAP: begin
                switch   = 1'b1;
                cnt_nx   = '0;
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                act_valid = 1'b1;
                act_addr  = cnt;
                // terminal compare at num_vec-1 keeps the max count from wrapping
                if (cnt == nv_q - VEC_W'(1)) begin
                    cnt_nx   = '0;
                    state_nx = S_DRAIN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    valid_delay #(
        .DEPTH(FILL),
        .W    (1 + VEC_W)
    ) u_delay (
        .clk  (clk),
        .clear(rst),
        .din  ({act_valid, act_addr}),
        .dout (res_bus)
    );

    assign {res_valid, res_addr} = res_bus;

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq: jobs push timed expected strobes into
// queues, a negedge monitor pops and compares whenever a strobe appears.
module tb_systolic_seq;

    localparam int BIG = 1000000;

    typedef struct packed {
        int dut;
        int cyc;
        int addr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] nv_a = '0, nv_b = '0;

    logic busy_a, done_a, w_en_a, switch_a, act_valid_a, res_valid_a;
    logic [1:0] w_addr_a;
    logic [7:0] act_addr_a, res_addr_a;
    logic busy_b, done_b, w_en_b, switch_b, act_valid_b, res_valid_b;
    logic [0:0] w_addr_b;
    logic [7:0] act_addr_b, res_addr_b;

    systolic_seq #(.N(4), .PE_LAT(1), .VEC_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .num_vec(nv_a),
        .busy(busy_a), .done(done_a), .w_en(w_en_a), .w_addr(w_addr_a),
        .switch(switch_a), .act_valid(act_valid_a), .act_addr(act_addr_a),
        .res_valid(res_valid_a), .res_addr(res_addr_a)
    );

    systolic_seq #(.N(2), .PE_LAT(2), .VEC_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_vec(nv_b),
        .busy(busy_b), .done(done_b), .w_en(w_en_b), .w_addr(w_addr_b),
        .switch(switch_b), .act_valid(act_valid_b), .act_addr(act_addr_b),
        .res_valid(res_valid_b), .res_addr(res_addr_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    ev_t qw[$], qs[$], qa[$], qr[$], qd[$];

    task automatic chk_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_ev(input string nm, input ev_t e, input int d, input int a);
        n_cmp++;
        if (e.dut != d || e.cyc != cyc || e.addr != a) begin
            n_bad++;
            $display("FAIL %s: got dut%0d cycle %0d addr %0d, need dut%0d cycle %0d addr %0d",
                     nm, d, cyc, a, e.dut, e.cyc, e.addr);
        end
    endtask

    task automatic unexpected(input string nm, input int d, input int a);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got unexpected strobe dut%0d cycle %0d addr %0d, need none", nm, d, cyc, a);
    endtask

    task automatic mon_dut(input int d, input logic we, input int wa, input logic sw,
                           input logic av, input int aa, input logic rv, input int ra,
                           input logic dn);
        ev_t e;
        if (we) begin
            if (qw.size() == 0) unexpected("w_en", d, wa);
            else begin e = qw.pop_front(); chk_ev("w_en", e, d, wa); end
        end else chk_int("w_addr_idle", wa, 0);
        if (sw) begin
            if (qs.size() == 0) unexpected("switch", d, 0);
            else begin e = qs.pop_front(); chk_ev("switch", e, d, 0); end
        end
        if (av) begin
            if (qa.size() == 0) unexpected("act_valid", d, aa);
            else begin e = qa.pop_front(); chk_ev("act_valid", e, d, aa); end
        end else chk_int("act_addr_idle", aa, 0);
        if (rv) begin
            if (qr.size() == 0) unexpected("res_valid", d, ra);
            else begin e = qr.pop_front(); chk_ev("res_valid", e, d, ra); end
        end else chk_int("res_addr_idle", ra, 0);
        if (dn) begin
            if (qd.size() == 0) unexpected("done", d, 0);
            else begin e = qd.pop_front(); chk_ev("done", e, d, 0); end
        end
    endtask

    always @(negedge clk) begin
        mon_dut(0, w_en_a, int'(w_addr_a), switch_a, act_valid_a, int'(act_addr_a),
                res_valid_a, int'(res_addr_a), done_a);
        mon_dut(1, w_en_b, int'(w_addr_b), switch_b, act_valid_b, int'(act_addr_b),
                res_valid_b, int'(res_addr_b), done_b);
    end

    // Expected strobe timeline relative to the cycle start is sampled;
    // events at or after 'cut' are not expected (job aborted by reset).
    task automatic push_job(input int d, input int t0, input int nv, input int n,
                            input int fill, input int done_rel, input int cut);
        if (nv != 0) begin
            for (int i = 0; i < n; i++)
                if (1 + i < cut) qw.push_back('{d, t0 + 1 + i, i});
            if (n + 1 < cut) qs.push_back('{d, t0 + n + 1, 0});
            for (int i = 0; i < nv; i++) begin
                if (n + 2 + i < cut) qa.push_back('{d, t0 + n + 2 + i, i});
                if (n + 2 + fill + i < cut) qr.push_back('{d, t0 + n + 2 + fill + i, i});
            end
        end
        if (done_rel < cut) qd.push_back('{d, t0 + done_rel, 0});
    endtask

    task automatic go(input int d, input int nv, input int n, input int fill,
                      input int done_rel, input int cut, output int t0);
        @(negedge clk);
        t0 = cyc;
        if (d == 0) begin start_a = 1'b1; nv_a = 8'(nv); end
        else begin start_b = 1'b1; nv_b = 8'(nv); end
        push_job(d, t0, nv, n, fill, done_rel, cut);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input string nm, input int t0, input int end_rel);
        int k;
        int left;
        k = 0;
        while ((busy_a || busy_b || qw.size() != 0 || qs.size() != 0 || qa.size() != 0 ||
                qr.size() != 0 || qd.size() != 0) && k < 600) begin
            @(negedge clk);
            #1;
            k++;
        end
        left = qw.size() + qs.size() + qa.size() + qr.size() + qd.size();
        if (k >= 600) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busy/pending after 600 cycles, need idle", nm);
        end
        chk_int({nm, "_idle_cycle"}, cyc - t0, end_rel);
        chk_int({nm, "_pending"}, left, 0);
        qw.delete(); qs.delete(); qa.delete(); qr.delete(); qd.delete();
    endtask

    task automatic chk_quiet_a(input string nm);
        chk_int({nm, "_strobes"},
                int'({busy_a, done_a, w_en_a, switch_a, act_valid_a, res_valid_a}), 0);
        chk_int({nm, "_addrs"}, int'(w_addr_a) + int'(act_addr_a) + int'(res_addr_a), 0);
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet_a("reset_a");
        chk_int("reset_b", int'({busy_b, done_b, w_en_b, switch_b, act_valid_b, res_valid_b}), 0);

        // basic: N=4, FILL=4, num_vec=3 -> done at 16, idle at 17
        go(0, 3, 4, 4, 16, BIG, t0);
        chk_int("basic_busy_c1", int'(busy_a), 1);
        wait_idle("basic", t0, 17);

        // zero length -> done at 1, no array activity
        go(0, 0, 4, 4, 1, BIG, t0);
        wait_idle("zero", t0, 2);

        // back-to-back, start held: job1 done at 14, job2 sampled at 15, done at 29
        @(negedge clk);
        t0 = cyc;
        start_a = 1'b1;
        nv_a = 8'd1;
        push_job(0, t0, 1, 4, 4, 14, BIG);
        push_job(0, t0 + 15, 1, 4, 4, 14, BIG);
        while (cyc < t0 + 20) @(negedge clk);
        start_a = 1'b0;
        #1;
        wait_idle("b2b", t0, 30);

        // mid-job reset at cycle 7 of the basic job
        go(0, 3, 4, 4, 16, 8, t0);
        while (cyc < t0 + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet_a("midrst_c8");
        wait_idle("midrst", t0, 8);
        repeat (12) @(negedge clk);
        #1;
        go(0, 3, 4, 4, 16, BIG, t0);
        wait_idle("after_rst", t0, 17);

        // max count: done at 2*4+255+4+1 = 268
        go(0, 255, 4, 4, 268, BIG, t0);
        wait_idle("max", t0, 269);

        // sweep: N=2, PE_LAT=2, FILL=4, num_vec=2 -> done at 11
        go(1, 2, 2, 4, 11, BIG, t0);
        wait_idle("sweep", t0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_seq.md
# systolic_seq

Sequencer for one N×N weight-stationary systolic tile built from floating-point PEs. On `start`, the block runs four phases:
- shifts N weight rows into the array's dormant registers;
- pulses `switch` to make those weights active;
- streams `num_vec` activation vectors;
- flags the result stream at the bottom of the array.

It sits between the tile's SRAM buffers and the PE grid. It carries only control and addresses; no floating-point data passes through it.

## Interface
- `N`, 4, array rows = columns
- `PE_LAT`, 1, register stages per PE hop (activation/partial-sum path)
- `VEC_W`, 8, width of vector count and addresses
- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  job request; sampled only in IDLE
- `num_vec`  in  VEC_W  vectors to stream; latched with `start`
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse in DONE
- `w_en`  out  1  weight shift enable into the array's dormant path
- `w_addr`  out  $clog2(N)  weight-buffer row index
- `switch`  out  1  one-cycle dormant→active weight swap, broadcast to all PEs
- `act_valid`  out  1  row-0 activation valid (the feeder adds per-row skew r·PE_LAT)
- `act_addr`  out  VEC_W  activation vector index for row 0
- `res_valid`  out  1  column-0 result valid (the collector de-skews the other columns)
- `res_addr`  out  VEC_W  result vector index for column 0

## Operation
- States: IDLE, LOAD_W, SWAP, STREAM, DRAIN, DONE.
- IDLE → LOAD_W on `start` with `num_vec` ≠ 0. IDLE → DONE on `start` with `num_vec` = 0; no array activity occurs.
- LOAD_W lasts N cycles.
  - `w_en` = 1.
  - `w_addr` counts 0..N-1.
- SWAP lasts 1 cycle with `switch` = 1.
- STREAM lasts `num_vec` cycles.
  - `act_valid` = 1.
  - `act_addr` counts 0..num_vec-1.
- DRAIN lasts FILL+N-1 cycles, where FILL = N·PE_LAT.
- DONE lasts 1 cycle with `done` = 1, then returns to IDLE.
- `res_valid` is `act_valid` delayed by exactly FILL cycles. `res_addr` is `act_addr` delayed by the same FILL cycles, so the result stream spans late STREAM and DRAIN.
- Outside their phases, `w_en`, `switch`, `act_valid` and `res_valid` are 0, and the address outputs hold 0.
- `start` while `busy` is ignored. `num_vec` is not re-sampled mid-job.
- Counter arithmetic is unsigned VEC_W bits. `num_vec` = 2^VEC_W−1 is legal; no wrap occurs because the counter terminates at num_vec−1.

## Timing
- Reset value of every output: 0. State after reset: IDLE. The delay line is cleared.
- Cycle references below are relative to the cycle `start` is sampled (cycle 0):
  - LOAD_W: cycles 1..N.
  - SWAP: cycle N+1.
  - STREAM: cycles N+2..N+1+num_vec.
  - `res_valid`: cycles N+2+FILL..N+1+FILL+num_vec.
  - DONE: cycle N+2+num_vec+FILL+N-1.
  - IDLE: the cycle after DONE; a new `start` can be accepted there.
- Total latency from `start` to `done` is 2N+num_vec+FILL+1 cycles.
- `rst` asserted mid-job forces IDLE on the next edge. All outputs are 0 that cycle, the delay line is flushed, and no `done` is produced.
- `rst` and `start` asserted in the same cycle: reset wins.

## Structure
- Shared package `systolic_pkg`:
  - state enum.
  - default N, PE_LAT, VEC_W.
  - FILL = N·PE_LAT.
- One sub-module, `valid_delay`: a parameterised DEPTH×(1+VEC_W) shift register with synchronous clear. It produces `res_valid`/`res_addr` from `act_valid`/`act_addr`.
- FSM and phase counter live in `systolic_seq`.

## Test plan
- **Basic job:** N=4, PE_LAT=1, `num_vec`=3, `start` at cycle 0.
  - `w_en` cycles 1–4 with `w_addr` 0..3.
  - `switch` at 5.
  - `act_valid` 6–8 with `act_addr` 0..2.
  - `res_valid` 10–12 with `res_addr` 0..2.
  - `done` at 16; `busy` 1..16.
- **Zero length:** `num_vec`=0.
  - `done` at cycle 1.
  - `w_en`, `switch`, `act_valid`, `res_valid` never asserted.
- **Back-to-back:** `start` held high continuously, `num_vec`=1.
  - Second job's LOAD_W begins the cycle after the first DONE→IDLE cycle.
  - `start` during `busy` is ignored.
- **Mid-job reset:** `rst` pulsed at cycle 7 of the basic job.
  - All outputs 0 at cycle 8.
  - No `res_valid` afterwards; no `done`.
  - A new `start` runs a clean, complete job.
- **Max count:** `num_vec`=255.
  - Exactly 255 `act_valid` and 255 `res_valid` cycles.
  - `act_addr` ends at 255−1 = 254; `res_addr` ends at 254.
  - `done` at 2N+255+FILL+1.
- **Parameter sweep:** PE_LAT=2, N=2, `num_vec`=2.
  - `res_valid` lags `act_valid` by exactly 4 cycles.
  - DRAIN length 5; `done` at cycle 11.
